// File: rtl/bms_pkg.sv
// Shared definitions for the battery-management blocks.
//   state_t          : charge-controller FSM state encodings (3 bits)
//   DEF_SOC_*        : default SOC thresholds and hysteresis, in percent
//   DEF_DEBOUNCE_CNT : default number of consecutive fault samples to trip
//   is_hold()        : true for either protective hold state
package bms_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHARGE    = 3'd1,
    ST_DISCHARGE = 3'd2,
    ST_CHG_HOLD  = 3'd3,
    ST_DSG_HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] DEF_SOC_LOW_LIMIT  = 8'd10;
  localparam logic [7:0] DEF_SOC_HIGH_LIMIT = 8'd95;
  localparam logic [7:0] DEF_SOC_HYST       = 8'd5;
  localparam logic [3:0] DEF_DEBOUNCE_CNT   = 4'd4;

  function automatic logic is_hold(input state_t s);
    return (s == ST_CHG_HOLD) || (s == ST_DSG_HOLD);
  endfunction

endpackage

// File: rtl/soc_protection.sv
// Combinational SOC limit comparator.
//   soc_percent : SOC estimate, 0..100
//   low_fault   : SOC at or below LOW_LIMIT
//   high_fault  : SOC at or above HIGH_LIMIT (suppressed when low_fault is set)
module soc_protection
  import bms_pkg::*;
#(
  parameter logic [7:0] LOW_LIMIT  = DEF_SOC_LOW_LIMIT,
  parameter logic [7:0] HIGH_LIMIT = DEF_SOC_HIGH_LIMIT
) (
  input  logic [7:0] soc_percent,
  output logic       low_fault,
  output logic       high_fault
);

  // Low fault wins so the controller never sees both faults in one sample.
  always_comb begin
    low_fault  = (soc_percent <= LOW_LIMIT);
    high_fault = !low_fault && (soc_percent >= HIGH_LIMIT);
  end

endmodule

// File: rtl/soc_charge_controller.sv
// SOC-based charge/discharge contactor controller.
//   clk, rst                    : clock and synchronous active-high reset
//   soc_percent, soc_valid      : SOC estimate and its one-cycle sample strobe
//   charge_req, discharge_req   : level requests from the pack supervisor
//   charge_en, discharge_en     : contactor enables, decoded from the state register
//   state                       : current FSM state code
//   fault_event                 : one-cycle pulse on each entry to a hold state
//   trip_count                  : saturating number of trips since reset
module soc_charge_controller
  import bms_pkg::*;
#(
  parameter logic [7:0] SOC_LOW_LIMIT  = DEF_SOC_LOW_LIMIT,
  parameter logic [7:0] SOC_HIGH_LIMIT = DEF_SOC_HIGH_LIMIT,
  parameter logic [7:0] SOC_HYST       = DEF_SOC_HYST,
  parameter logic [3:0] DEBOUNCE_CNT   = DEF_DEBOUNCE_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] soc_percent,
  input  logic       soc_valid,
  input  logic       charge_req,
  input  logic       discharge_req,
  output logic       charge_en,
  output logic       discharge_en,
  output logic [2:0] state,
  output logic       fault_event,
  output logic [7:0] trip_count
);

  // Release points for the hold states, fixed at elaboration.
  localparam logic [7:0] HIGH_RELEASE = SOC_HIGH_LIMIT - SOC_HYST;
  localparam logic [7:0] LOW_RELEASE  = SOC_LOW_LIMIT + SOC_HYST;

  state_t     state_q, state_d;
  logic [3:0] low_cnt_q, low_cnt_d;
  logic [3:0] high_cnt_q, high_cnt_d;
  logic       fault_event_q, fault_event_d;
  logic [7:0] trip_count_q, trip_count_d;

  logic low_fault, high_fault;
  logic low_trip, high_trip;
  logic clr_low, clr_high;
  logic enter_hold;

  soc_protection #(
    .LOW_LIMIT  (SOC_LOW_LIMIT),
    .HIGH_LIMIT (SOC_HIGH_LIMIT)
  ) u_protection (
    .soc_percent (soc_percent),
    .low_fault   (low_fault),
    .high_fault  (high_fault)
  );

  assign low_trip  = (low_cnt_q == DEBOUNCE_CNT);
  assign high_trip = (high_cnt_q == DEBOUNCE_CNT);

  // Next-state logic. Leaving a hold state also asks the debounce logic to
  // forget the trip, otherwise the saturated counter would re-trip at once.
  always_comb begin
    state_d  = state_q;
    clr_low  = 1'b0;
    clr_high = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (charge_req && !discharge_req && !high_trip) begin
          state_d = ST_CHARGE;
        end else if (discharge_req && !charge_req && !low_trip) begin
          state_d = ST_DISCHARGE;
        end
      end
      ST_CHARGE: begin
        if (high_trip) begin
          state_d = ST_CHG_HOLD;
        end else if (!charge_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_DISCHARGE: begin
        if (low_trip) begin
          state_d = ST_DSG_HOLD;
        end else if (!discharge_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHG_HOLD: begin
        if (!charge_req || (soc_valid && (soc_percent <= HIGH_RELEASE))) begin
          state_d  = ST_IDLE;
          clr_high = 1'b1;
        end
      end
      ST_DSG_HOLD: begin
        if (!discharge_req || (soc_valid && (soc_percent >= LOW_RELEASE))) begin
          state_d = ST_IDLE;
          clr_low = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Debounce counters advance only on valid samples and saturate at the trip level.
  always_comb begin
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    if (soc_valid) begin
      if (!low_fault) begin
        low_cnt_d = 4'd0;
      end else if (low_cnt_q < DEBOUNCE_CNT) begin
        low_cnt_d = low_cnt_q + 4'd1;
      end
      if (!high_fault) begin
        high_cnt_d = 4'd0;
      end else if (high_cnt_q < DEBOUNCE_CNT) begin
        high_cnt_d = high_cnt_q + 4'd1;
      end
    end
    if (clr_low) begin
      low_cnt_d = 4'd0;
    end
    if (clr_high) begin
      high_cnt_d = 4'd0;
    end
  end

  // A trip is registered on the same edge the FSM enters a hold state.
  always_comb begin
    enter_hold    = is_hold(state_d) && !is_hold(state_q);
    fault_event_d = enter_hold;
    trip_count_d  = trip_count_q;
    if (enter_hold && (trip_count_q != 8'hFF)) begin
      trip_count_d = trip_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      low_cnt_q     <= 4'd0;
      high_cnt_q    <= 4'd0;
      fault_event_q <= 1'b0;
      trip_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      fault_event_q <= fault_event_d;
      trip_count_q  <= trip_count_d;
    end
  end

  assign charge_en    = (state_q == ST_CHARGE);
  assign discharge_en = (state_q == ST_DISCHARGE);
  assign state        = state_q;
  assign fault_event  = fault_event_q;
  assign trip_count   = trip_count_q;

endmodule

// File: tb/tb_soc_charge_controller.sv
module tb_soc_charge_controller;

  logic       clk;
  logic       rst;
  logic [7:0] soc_percent;
  logic       soc_valid;
  logic       charge_req;
  logic       discharge_req;
  logic       charge_en;
  logic       discharge_en;
  logic [2:0] state_o;
  logic       fault_event;
  logic [7:0] trip_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       chg;
    logic       dsg;
    logic       valid;
    logic [7:0] soc;
    logic [2:0] st;
    logic       ce;
    logic       de;
    logic       fe;
    logic [7:0] tc;
  } vec_t;

  vec_t vecs[$];

  soc_charge_controller dut (
    .clk           (clk),
    .rst           (rst),
    .soc_percent   (soc_percent),
    .soc_valid     (soc_valid),
    .charge_req    (charge_req),
    .discharge_req (discharge_req),
    .charge_en     (charge_en),
    .discharge_en  (discharge_en),
    .state         (state_o),
    .fault_event   (fault_event),
    .trip_count    (trip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, then let exactly one rising edge consume them.
  task automatic applyStimulus(input logic r, input logic c, input logic d,
                               input logic v, input logic [7:0] s);
    rst           = r;
    charge_req    = c;
    discharge_req = d;
    soc_valid     = v;
    soc_percent   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic ce,
                             input logic de, input logic fe, input logic [7:0] tc);
    checks++;
    if (state_o !== st || charge_en !== ce || discharge_en !== de ||
        fault_event !== fe || trip_count !== tc) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d ce=%b de=%b fe=%b tc=%0d, want st=%0d ce=%b de=%b fe=%b tc=%0d",
               name, state_o, charge_en, discharge_en, fault_event, trip_count,
               st, ce, de, fe, tc);
    end
  endtask

  task automatic addVec(input logic r, input logic c, input logic d, input logic v,
                        input logic [7:0] s, input logic [2:0] st, input logic ce,
                        input logic de, input logic fe, input logic [7:0] tc);
    vec_t x;
    x.rst = r; x.chg = c; x.dsg = d; x.valid = v; x.soc = s;
    x.st = st; x.ce = ce; x.de = de; x.fe = fe; x.tc = tc;
    vecs.push_back(x);
  endtask

  // Keep stepping with the given inputs until the DUT reaches a hold state.
  task automatic waitHold(input logic c, input logic d, input logic [7:0] s,
                          input logic [2:0] hold_st, input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, c, d, 1'b1, s);
      if (state_o == hold_st) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout, state=%0d want %0d", name, state_o, hold_st);
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1; charge_req = 1'b0; discharge_req = 1'b0;
    soc_valid = 1'b0; soc_percent = 8'd0;

    //      rst chg dsg vld soc      st  ce  de  fe  tc
    addVec(1, 0, 0, 0, 8'd0,   0, 0, 0, 0, 8'd0);
    addVec(0, 1, 0, 1, 8'd90,  1, 1, 0, 0, 8'd0);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd0);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd0);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd0);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd0);
    addVec(0, 1, 0, 1, 8'd96,  3, 0, 0, 1, 8'd1);
    addVec(0, 1, 0, 1, 8'd96,  3, 0, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd91,  3, 0, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd90,  0, 0, 0, 0, 8'd1);
    addVec(0, 1, 0, 0, 8'd0,   1, 1, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd94,  1, 1, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd1);
    addVec(0, 1, 0, 1, 8'd96,  1, 1, 0, 0, 8'd1);
    addVec(0, 0, 0, 0, 8'd0,   0, 0, 0, 0, 8'd1);
    addVec(0, 0, 1, 1, 8'd50,  2, 0, 1, 0, 8'd1);
    addVec(0, 0, 1, 1, 8'd10,  2, 0, 1, 0, 8'd1);
    addVec(0, 0, 1, 1, 8'd10,  2, 0, 1, 0, 8'd1);
    addVec(0, 0, 1, 1, 8'd10,  2, 0, 1, 0, 8'd1);
    addVec(0, 0, 1, 1, 8'd10,  2, 0, 1, 0, 8'd1);
    addVec(0, 0, 1, 1, 8'd10,  4, 0, 0, 1, 8'd2);
    addVec(0, 0, 1, 1, 8'd14,  4, 0, 0, 0, 8'd2);
    addVec(0, 0, 1, 1, 8'd15,  0, 0, 0, 0, 8'd2);
    addVec(0, 1, 1, 0, 8'd0,   0, 0, 0, 0, 8'd2);
    addVec(0, 1, 1, 1, 8'd50,  0, 0, 0, 0, 8'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].chg, vecs[i].dsg, vecs[i].valid, vecs[i].soc);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ce, vecs[i].de,
                  vecs[i].fe, vecs[i].tc);
    end

    // Reset taken while parked in DSG_HOLD, then IDLE rules apply immediately.
    waitHold(1'b0, 1'b1, 8'd5, 3'd4, "dsg_hold_entry", ok);
    if (ok) checkOutput("dsg_hold_entry", 3'd4, 1'b0, 1'b0, 1'b1, 8'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd5);
    checkOutput("reset_in_hold", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    checkOutput("first_after_reset", 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);

    // Trip counter saturation over 258 charge trips.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int t = 1; t <= 258; t++) begin
      waitHold(1'b1, 1'b0, 8'd96, 3'd3, $sformatf("sat_trip%0d", t), ok);
      if (!ok) break;
      if (t == 1)   checkOutput("sat_trip1", 3'd3, 1'b0, 1'b0, 1'b1, 8'd1);
      if (t == 254) checkOutput("sat_trip254", 3'd3, 1'b0, 1'b0, 1'b1, 8'hFE);
      if (t == 256) checkOutput("sat_trip256", 3'd3, 1'b0, 1'b0, 1'b1, 8'hFF);
      if (t == 258) checkOutput("sat_trip258", 3'd3, 1'b0, 1'b0, 1'b1, 8'hFF);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd96);
    end
    checkOutput("sat_final_idle", 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
